// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared flappy game geometry, one-hot FSM states and BCD helpers
package flappy_pkg;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int PIPE_RESPAWN_X = 1000;
  localparam int PIPE_W         = 60;
  localparam int GAP_H          = 140;
  localparam int BIRD_X         = 200;
  localparam int BIRD_W         = 20;
  localparam int BIRD_H         = 20;
  localparam int HIT_CONFIRM    = 2;

  // One-hot encodings are shared with the pipe and bird movers.
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_PLAY = 5'b00010,
    ST_HIT  = 5'b00100,
    ST_LOST = 5'b01000
  } state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Packed BCD digits order the same way as the decimal value.
  function automatic logic bcd2_gt(bcd2_t a, bcd2_t b);
    return {a.tens, a.ones} > {b.tens, b.ones};
  endfunction

endpackage

// File: rtl/pipe_collision_scorer_if.sv
// rtl/pipe_collision_scorer_if.sv - game-side signals between movers, scorer and display
interface pipe_collision_scorer_if;

  logic       Start;
  logic [9:0] PipePosXA;
  logic [9:0] PipePosYA;
  logic [9:0] BirdPosY;
  logic       Lost;
  logic       HitPulse;
  logic [3:0] ScoreTens;
  logic [3:0] ScoreOnes;
  logic [3:0] HighTens;
  logic [3:0] HighOnes;
  logic [4:0] State;

  modport master (
    output Start, PipePosXA, PipePosYA, BirdPosY,
    input  Lost, HitPulse, ScoreTens, ScoreOnes, HighTens, HighOnes, State
  );

  modport slave (
    input  Start, PipePosXA, PipePosYA, BirdPosY,
    output Lost, HitPulse, ScoreTens, ScoreOnes, HighTens, HighOnes, State
  );

endinterface

// File: rtl/bcd_counter_2d.sv
// rtl/bcd_counter_2d.sv - two-digit BCD counter saturating at 99, with load and load-compare
module bcd_counter_2d
  import flappy_pkg::*;
(
  input  logic  Clk,
  input  logic  Reset,
  input  logic  inc_i,
  input  logic  clr_i,
  input  logic  load_i,
  input  bcd2_t load_val_i,
  output bcd2_t cnt_o,
  output logic  load_gt_o
);

  bcd2_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && !(cnt_q.tens == 4'd9 && cnt_q.ones == 4'd9)) begin
      if (cnt_q.ones == 4'd9) begin
        cnt_d.ones = 4'd0;
        cnt_d.tens = cnt_q.tens + 4'd1;
      end else begin
        cnt_d.ones = cnt_q.ones + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign load_gt_o = bcd2_gt(load_val_i, cnt_q);

endmodule

// File: rtl/pipe_collision_scorer.sv
// rtl/pipe_collision_scorer.sv - bird/pipe and screen-edge collision detection, BCD score and high score
module pipe_collision_scorer
  import flappy_pkg::*;
#(
  parameter int HIT_CONFIRM_CYC = HIT_CONFIRM
) (
  input logic                     Clk,
  input logic                     Reset,
  pipe_collision_scorer_if.slave  io
);

  localparam logic [10:0] BX = 11'(BIRD_X);
  localparam logic [10:0] BW = 11'(BIRD_W);
  localparam logic [10:0] BH = 11'(BIRD_H);
  localparam logic [10:0] PW = 11'(PIPE_W);
  localparam logic [10:0] GH = 11'(GAP_H);
  localparam logic [10:0] SH = 11'(SCREEN_H);
  localparam logic [3:0]  HC = 4'(HIT_CONFIRM_CYC);

  logic [10:0] x11, py11, by11;
  logic        xov, yout, edge_hit;
  logic        overlap_q, passed_q;
  logic        passed_prev_q, passed_prev_d;
  logic [3:0]  hit_cnt_q, hit_cnt_d;
  state_e      state_q, state_d;
  logic        score_inc, score_clr, high_load;
  bcd2_t       score, high;
  logic        high_gt, score_gt_unused;

  // Widen to 11 bits so X up to 1023 plus pipe width cannot wrap.
  assign x11  = {1'b0, io.PipePosXA};
  assign py11 = {1'b0, io.PipePosYA};
  assign by11 = {1'b0, io.BirdPosY};

  assign xov      = (x11 < BX + BW) && (x11 + PW > BX);
  assign yout     = (by11 < py11) || (by11 + BH > py11 + GH);
  assign edge_hit = (by11 == 11'd0) || (by11 + BH >= SH);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      overlap_q     <= 1'b0;
      passed_q      <= 1'b0;
      passed_prev_q <= 1'b0;
      hit_cnt_q     <= '0;
      state_q       <= ST_IDLE;
    end else begin
      overlap_q     <= (xov && yout) || edge_hit;
      passed_q      <= (x11 + PW <= BX);
      passed_prev_q <= passed_prev_d;
      hit_cnt_q     <= hit_cnt_d;
      state_q       <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hit_cnt_d     = hit_cnt_q;
    passed_prev_d = passed_q;
    score_inc     = 1'b0;
    score_clr     = 1'b0;
    high_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io.Start) begin
          state_d       = ST_PLAY;
          score_clr     = 1'b1;
          hit_cnt_d     = '0;
          passed_prev_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (!io.Start) begin
          state_d = ST_IDLE;
        end else begin
          if (overlap_q) hit_cnt_d = (hit_cnt_q >= HC) ? HC : hit_cnt_q + 4'd1;
          else           hit_cnt_d = '0;
          // A pass landing on the same edge as the hit is dropped.
          if (hit_cnt_d == HC)                     state_d   = ST_HIT;
          else if (passed_q && !passed_prev_q)     score_inc = 1'b1;
        end
      end
      ST_HIT: begin
        state_d   = ST_LOST;
        high_load = high_gt;
      end
      ST_LOST: begin
        if (!io.Start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bcd_counter_2d u_score (
    .Clk        (Clk),
    .Reset      (Reset),
    .inc_i      (score_inc),
    .clr_i      (score_clr),
    .load_i     (1'b0),
    .load_val_i (high),
    .cnt_o      (score),
    .load_gt_o  (score_gt_unused)
  );

  bcd_counter_2d u_high (
    .Clk        (Clk),
    .Reset      (Reset),
    .inc_i      (1'b0),
    .clr_i      (1'b0),
    .load_i     (high_load),
    .load_val_i (score),
    .cnt_o      (high),
    .load_gt_o  (high_gt)
  );

  assign io.Lost      = (state_q == ST_LOST);
  assign io.HitPulse  = (state_q == ST_HIT);
  assign io.ScoreTens = score.tens;
  assign io.ScoreOnes = score.ones;
  assign io.HighTens  = high.tens;
  assign io.HighOnes  = high.ones;
  assign io.State     = state_q;

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// tb/tb_pipe_collision_scorer.sv - directed self-checking bench for pipe_collision_scorer
module tb_pipe_collision_scorer;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 Clk = ~Clk;

  pipe_collision_scorer_if bus ();

  pipe_collision_scorer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .io    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic st, input int x, input int py, input int by);
    bus.Start     = st;
    bus.PipePosXA = 10'(x);
    bus.PipePosYA = 10'(py);
    bus.BirdPosY  = 10'(by);
  endtask

  function automatic logic [7:0] score_v();
    return {bus.ScoreTens, bus.ScoreOnes};
  endfunction

  function automatic logic [7:0] high_v();
    return {bus.HighTens, bus.HighOnes};
  endfunction

  // Sweeps the pipe left past a centred bird; base is the score before the sweep.
  task automatic sweep(input int base, input string tag);
    logic seen;
    seen = 1'b0;
    for (int x = 300; x >= 0; x--) begin
      bus.PipePosXA = 10'(x);
      tick();
      if (bus.Lost || bus.HitPulse) seen = 1'b1;
      if (x == 140) chk({tag, "_lat_before"}, {24'd0, score_v()}, 32'(base));
      if (x == 139) chk({tag, "_lat_after"}, {24'd0, score_v()}, 32'(base + 1));
    end
    chk({tag, "_nohit"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic seen;

    // T1 reset held with Start=1
    drive(1'b1, 500, 150, 200);
    repeat (3) tick();
    chk("t1_state", {27'd0, bus.State}, 32'h01);
    chk("t1_lost", {31'd0, bus.Lost}, 32'd0);
    chk("t1_hitpulse", {31'd0, bus.HitPulse}, 32'd0);
    chk("t1_score", {24'd0, score_v()}, 32'h00);
    chk("t1_high", {24'd0, high_v()}, 32'h00);

    // T2 clean passes
    Reset = 1'b1;
    tick();
    chk("t2_play", {27'd0, bus.State}, 32'h02);
    sweep(0, "t2a");
    chk("t2_score1", {24'd0, score_v()}, 32'h01);
    bus.PipePosXA = 10'd1000;
    tick();
    chk("t2_respawn_hold", {24'd0, score_v()}, 32'h01);
    sweep(1, "t2b");
    chk("t2_score2", {24'd0, score_v()}, 32'h02);

    // T3 pipe hit
    drive(1'b1, 190, 150, 100);
    tick(); tick();
    chk("t3_pre_hit", {31'd0, bus.HitPulse}, 32'd0);
    tick();
    chk("t3_hitpulse", {31'd0, bus.HitPulse}, 32'd1);
    chk("t3_state_hit", {27'd0, bus.State}, 32'h04);
    tick();
    chk("t3_lost", {31'd0, bus.Lost}, 32'd1);
    chk("t3_pulse_end", {31'd0, bus.HitPulse}, 32'd0);
    chk("t3_state_lost", {27'd0, bus.State}, 32'h08);
    chk("t3_high", {24'd0, high_v()}, 32'h02);
    chk("t3_score_frozen", {24'd0, score_v()}, 32'h02);
    drive(1'b0, 500, 150, 200);
    tick();
    chk("t3_idle", {27'd0, bus.State}, 32'h01);
    chk("t3_idle_score", {24'd0, score_v()}, 32'h02);
    bus.Start = 1'b1;
    tick();
    chk("t3_replay", {27'd0, bus.State}, 32'h02);
    chk("t3_score_clr", {24'd0, score_v()}, 32'h00);
    chk("t3_high_keep", {24'd0, high_v()}, 32'h02);

    // T4 single-cycle overlap is filtered
    drive(1'b1, 190, 150, 100);
    tick();
    seen = bus.HitPulse;
    drive(1'b1, 500, 150, 200);
    repeat (4) begin
      tick();
      if (bus.HitPulse || bus.Lost) seen = 1'b1;
    end
    chk("t4_no_hit", {31'd0, seen}, 32'd0);
    chk("t4_state", {27'd0, bus.State}, 32'h02);

    // T5 bottom and top screen edges
    drive(1'b1, 500, 150, 460);
    repeat (3) tick();
    chk("t5_bot_pulse", {31'd0, bus.HitPulse}, 32'd1);
    tick();
    chk("t5_bot_lost", {31'd0, bus.Lost}, 32'd1);
    chk("t5_high_keep", {24'd0, high_v()}, 32'h02);
    drive(1'b0, 500, 150, 200);
    tick();
    bus.Start = 1'b1;
    tick();
    chk("t5_replay", {27'd0, bus.State}, 32'h02);
    drive(1'b1, 500, 150, 0);
    repeat (3) tick();
    chk("t5_top_pulse", {31'd0, bus.HitPulse}, 32'd1);
    tick();
    chk("t5_top_lost", {31'd0, bus.Lost}, 32'd1);
    drive(1'b0, 500, 150, 200);
    tick();
    bus.Start = 1'b1;
    tick();
    chk("t5_restart", {27'd0, bus.State}, 32'h02);

    // T6 saturation at 99 and high score carry over restart
    for (int i = 1; i <= 100; i++) begin
      bus.PipePosXA = 10'd100;
      tick();
      bus.PipePosXA = 10'd1000;
      tick();
      if (i == 10) chk("t6_score10", {24'd0, score_v()}, 32'h10);
      if (i == 99) chk("t6_score99", {24'd0, score_v()}, 32'h99);
    end
    chk("t6_sat", {24'd0, score_v()}, 32'h99);
    drive(1'b1, 190, 150, 100);
    repeat (4) tick();
    chk("t6_lost", {31'd0, bus.Lost}, 32'd1);
    chk("t6_high99", {24'd0, high_v()}, 32'h99);
    drive(1'b0, 500, 150, 200);
    tick();
    chk("t6_idle", {27'd0, bus.State}, 32'h01);
    bus.Start = 1'b1;
    tick();
    chk("t6_score_clr", {24'd0, score_v()}, 32'h00);
    chk("t6_high_keep", {24'd0, high_v()}, 32'h99);

    // T7 mid-game reset
    Reset = 1'b0;
    tick();
    chk("t7_state", {27'd0, bus.State}, 32'h01);
    chk("t7_high", {24'd0, high_v()}, 32'h00);
    Reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
